// File: rtl/cei_obi_addr_router.sv
// cei_obi_addr_router: 1-master -> NSLAVE OBI address router.
// Each request is decoded against a rule table that can be rewritten at run time.
// The table is loaded from RULES_INIT at reset.
// Granted requests are tracked in order in a FIFO of decoded targets.
// Addresses that match no rule go to an internal error responder (ERR).
// Optional feature: define CEI_ADDR_ROUTER_ERRCNT_EN to add a saturating
// counter of accepted ERR requests (err_cnt_clr_i / err_cnt_o).

package cei_obi_addr_router_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] start_addr;
    logic [31:0] end_addr;   // exclusive
    logic [31:0] slave_idx;
  } addr_map_rule_t;

  localparam addr_map_rule_t [4:0] DEFAULT_RULES = '{
    addr_map_rule_t'{valid: 1'b1, start_addr: 32'hF011_0000, end_addr: 32'hF012_0000, slave_idx: 32'd4},
    addr_map_rule_t'{valid: 1'b1, start_addr: 32'hF010_0000, end_addr: 32'hF011_0000, slave_idx: 32'd3},
    addr_map_rule_t'{valid: 1'b1, start_addr: 32'hF001_0000, end_addr: 32'hF002_0000, slave_idx: 32'd2},
    addr_map_rule_t'{valid: 1'b1, start_addr: 32'hF000_0000, end_addr: 32'hF001_0000, slave_idx: 32'd1},
    addr_map_rule_t'{valid: 1'b1, start_addr: 32'h0000_0000, end_addr: 32'h0001_0000, slave_idx: 32'd0}
  };
endpackage

module cei_obi_addr_router
  import cei_obi_addr_router_pkg::*;
#(
  parameter int                             NSLAVE          = 5,
  parameter int                             NRULES          = 5,
  parameter int                             DW              = 32,
  parameter int                             MAX_OUTSTANDING = 4,
  parameter logic [DW-1:0]                  ERR_RDATA       = DW'(32'hBADACCE5),
  parameter addr_map_rule_t [NRULES-1:0]    RULES_INIT      = DEFAULT_RULES,
  localparam int                            IW              = (NRULES > 1) ? $clog2(NRULES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m_req_i,
  input  logic [31:0]          m_addr_i,
  input  logic                 m_we_i,
  input  logic [DW/8-1:0]      m_be_i,
  input  logic [DW-1:0]        m_wdata_i,
  output logic                 m_gnt_o,
  output logic                 m_rvalid_o,
  output logic [DW-1:0]        m_rdata_o,
  output logic                 m_err_o,
  output logic [NSLAVE-1:0]    s_req_o,
  output logic [31:0]          s_addr_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_be_o,
  output logic [DW-1:0]        s_wdata_o,
  input  logic [NSLAVE-1:0]    s_gnt_i,
  input  logic [NSLAVE-1:0]    s_rvalid_i,
  input  logic [NSLAVE*DW-1:0] s_rdata_i,
  input  logic                 cfg_we_i,
  input  logic [IW-1:0]        cfg_idx_i,
  input  logic [31:0]          cfg_start_i,
  input  logic [31:0]          cfg_end_i,
  input  logic [31:0]          cfg_slave_i,
  input  logic                 cfg_valid_i,
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
  input  logic                 err_cnt_clr_i,
  output logic [15:0]          err_cnt_o,
`endif
  output logic                 proto_err_o
);

  // Target encoding: 0..NSLAVE-1 are real slaves, NSLAVE is the error responder.
  localparam int TW = $clog2(NSLAVE + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] ERR_ID = TW'(NSLAVE);

  addr_map_rule_t [NRULES-1:0] rules_q;
  logic [TW-1:0]               fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]               wptr_q, rptr_q;
  logic [CW-1:0]               cnt_q;
  logic                        proto_q;

  logic [TW-1:0] tgt, head;
  logic          full, empty, push, pop, proto_set;

  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];
  assign push  = m_req_i & m_gnt_o;
  assign pop   = m_rvalid_o;

  // Broadcast request fields; everything is held at 0 while in reset.
  assign s_addr_o    = rst_i ? '0 : m_addr_i;
  assign s_we_o      = rst_i ? 1'b0 : m_we_i;
  assign s_be_o      = rst_i ? '0 : m_be_i;
  assign s_wdata_o   = rst_i ? '0 : m_wdata_i;
  assign proto_err_o = proto_q & ~rst_i;

  // Rule table: a write lands next cycle; a write naming a nonexistent slave is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rules_q <= RULES_INIT;
    end else if (cfg_we_i && (cfg_slave_i < 32'(NSLAVE)) && (32'(cfg_idx_i) < 32'(NRULES))) begin
      rules_q[cfg_idx_i] <= '{valid: cfg_valid_i, start_addr: cfg_start_i,
                              end_addr: cfg_end_i, slave_idx: cfg_slave_i};
    end
  end

  // Decode: walking from the top down leaves the lowest-index hit in tgt.
  // A malformed RULES_INIT entry with an out-of-range slave never hits.
  always_comb begin
    tgt = ERR_ID;
    for (int i = NRULES - 1; i >= 0; i--) begin
      if (rules_q[i].valid && (m_addr_i >= rules_q[i].start_addr) &&
          (m_addr_i < rules_q[i].end_addr) && (rules_q[i].slave_idx < 32'(NSLAVE)))
        tgt = rules_q[i].slave_idx[TW-1:0];
    end
  end

  // Request path: stall completely when full, even if a pop happens in the same cycle.
  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (!rst_i && !full) begin
      if (tgt == ERR_ID) m_gnt_o = m_req_i;
      for (int k = 0; k < NSLAVE; k++) begin
        if (tgt == TW'(k)) begin
          s_req_o[k] = m_req_i;
          m_gnt_o    = s_gnt_i[k];
        end
      end
    end
  end

  // Response path: only the FIFO head slave may answer; any other rvalid is a protocol error.
  always_comb begin
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    proto_set  = 1'b0;
    if (!rst_i) begin
      if (!empty && head == ERR_ID) begin
        m_rvalid_o = 1'b1;
        m_rdata_o  = ERR_RDATA;
        m_err_o    = 1'b1;
      end
      for (int k = 0; k < NSLAVE; k++) begin
        if (!empty && head == TW'(k)) begin
          m_rvalid_o = s_rvalid_i[k];
          if (s_rvalid_i[k]) m_rdata_o = s_rdata_i[k*DW +: DW];
        end else if (s_rvalid_i[k]) begin
          proto_set = 1'b1;
        end
      end
    end
  end

  // In-order outstanding FIFO and the sticky protocol error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      proto_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      proto_q <= proto_q | proto_set;
      if (push) begin
        fifo_q[wptr_q] <= tgt;
        wptr_q <= (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) rptr_q <= (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
  logic [15:0] err_cnt_q;
  assign err_cnt_o = rst_i ? '0 : err_cnt_q;

  // Saturating count of accepted ERR requests; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || err_cnt_clr_i)                                  err_cnt_q <= '0;
    else if (push && tgt == ERR_ID && err_cnt_q != 16'hFFFF)      err_cnt_q <= err_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cei_obi_addr_router.sv
// Directed bench for cei_obi_addr_router (default parameters).
// A queue/array model is checked every cycle, and literal expectations pin key points.
module tb_cei_obi_addr_router;
  localparam int NS = 5;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_req, m_we;
  logic [31:0]   m_addr, m_wdata;
  logic [3:0]    m_be;
  logic          m_gnt, m_rvalid, m_err;
  logic [31:0]   m_rdata;
  logic [NS-1:0] s_req, s_gnt, s_rvalid;
  logic [31:0]   s_addr, s_wdata;
  logic          s_we;
  logic [3:0]    s_be;
  logic [NS*32-1:0] s_rdata;
  logic          cfg_we, cfg_valid;
  logic [2:0]    cfg_idx;
  logic [31:0]   cfg_start, cfg_end, cfg_slave;
  logic          proto_err;
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
  logic          err_clr;
  logic [15:0]   err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cei_obi_addr_router dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_start_i(cfg_start), .cfg_end_i(cfg_end),
    .cfg_slave_i(cfg_slave), .cfg_valid_i(cfg_valid),
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
    .err_cnt_clr_i(err_clr), .err_cnt_o(err_cnt),
`endif
    .proto_err_o(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        r_valid [NS];
  logic [31:0] r_start [NS];
  logic [31:0] r_end   [NS];
  int          r_slave [NS];
  int          q[$];          // outstanding targets, -1 = error responder
  logic        proto_m;
  int          errcnt_m;

  function automatic void model_reset();
    r_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    r_start = '{32'h0000_0000, 32'hF000_0000, 32'hF001_0000, 32'hF010_0000, 32'hF011_0000};
    r_end   = '{32'h0001_0000, 32'hF001_0000, 32'hF002_0000, 32'hF011_0000, 32'hF012_0000};
    r_slave = '{0, 1, 2, 3, 4};
    q.delete();
    proto_m  = 1'b0;
    errcnt_m = 0;
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (r_valid[i] && a >= r_start[i] && a < r_end[i]) return r_slave[i];
    return -1;
  endfunction

  initial model_reset();

  // Per-cycle compare, then advance the model with the inputs that the next posedge will see.
  always @(negedge clk) begin
    int          t, h;
    logic [NS-1:0] e_sreq;
    logic        e_gnt, e_rv, e_err, acc;
    logic [31:0] e_rd;
    if (rst) begin
      chk("rst_gnt", m_gnt, 0);       chk("rst_rvalid", m_rvalid, 0);
      chk("rst_rdata", m_rdata, 0);   chk("rst_err", m_err, 0);
      chk("rst_sreq", s_req, 0);      chk("rst_saddr", s_addr, 0);
      chk("rst_proto", proto_err, 0);
      model_reset();
    end else begin
      t = decode(m_addr);
      e_sreq = '0; e_gnt = 1'b0;
      if (q.size() < MO) begin
        if (t < 0) e_gnt = m_req;
        else begin e_sreq[t] = m_req; e_gnt = s_gnt[t]; end
      end
      e_rv = 1'b0; e_rd = '0; e_err = 1'b0; h = -2;
      if (q.size() > 0) begin
        h = q[0];
        if (h < 0) begin e_rv = 1'b1; e_rd = 32'hBADACCE5; e_err = 1'b1; end
        else begin e_rv = s_rvalid[h]; e_rd = e_rv ? s_rdata[h*32 +: 32] : 32'h0; end
      end
      chk("m_gnt", m_gnt, e_gnt);       chk("s_req", s_req, e_sreq);
      chk("m_rvalid", m_rvalid, e_rv);  chk("m_rdata", m_rdata, e_rd);
      chk("m_err", m_err, e_err);       chk("proto_err", proto_err, proto_m);
      chk("s_addr", s_addr, m_addr);    chk("s_wdata", s_wdata, m_wdata);
      chk("s_we", s_we, m_we);          chk("s_be", s_be, m_be);
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
      chk("err_cnt", err_cnt, errcnt_m);
`endif
      for (int k = 0; k < NS; k++) if (s_rvalid[k] && h != k) proto_m = 1'b1;
      acc = m_req && e_gnt;
      if (cfg_we && cfg_slave < NS) begin
        r_valid[cfg_idx] = cfg_valid; r_start[cfg_idx] = cfg_start;
        r_end[cfg_idx] = cfg_end;     r_slave[cfg_idx] = int'(cfg_slave);
      end
      if (e_rv) void'(q.pop_front());
      if (acc) q.push_back(t);
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
      if (err_clr) errcnt_m = 0;
      else if (acc && t < 0 && errcnt_m < 16'hFFFF) errcnt_m++;
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m_req = 0; s_gnt = '0; s_rvalid = '0; cfg_we = 0;
  endtask

  task automatic req(input logic [31:0] a, input logic [NS-1:0] g);
    m_req = 1; m_addr = a; s_gnt = g;
  endtask

  initial begin
    rst = 1; idle(); m_addr = '0; m_we = 0; m_be = 4'hF; m_wdata = 32'h5555_AAAA;
    s_rdata = '0; cfg_idx = '0; cfg_start = '0; cfg_end = '0; cfg_slave = '0; cfg_valid = 0;
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
    err_clr = 0;
`endif
    cyc(); cyc();
    rst = 0;

    // 1: routed read to slave 3
    cyc(); req(32'hF010_0004, 5'b01000);
    @(negedge clk); chk("t1_sreq", s_req, 5'b01000); chk("t1_gnt", m_gnt, 1);
    cyc(); idle(); s_rvalid = 5'b01000; s_rdata[3*32 +: 32] = 32'h1234;
    @(negedge clk); chk("t1_rv", m_rvalid, 1); chk("t1_rd", m_rdata, 32'h1234); chk("t1_err", m_err, 0);

    // 2: unmapped address -> error responder
    cyc(); idle(); req(32'hF003_0000, '0);
    @(negedge clk); chk("t2_gnt", m_gnt, 1); chk("t2_sreq", s_req, 0);
    cyc(); idle();
    @(negedge clk); chk("t2_rv", m_rvalid, 1); chk("t2_rd", m_rdata, 32'hBADACCE5); chk("t2_err", m_err, 1);
`ifdef CEI_ADDR_ROUTER_ERRCNT_EN
    cyc(); @(negedge clk); chk("t2_errcnt", err_cnt, 1);
`endif

    // 3: fill to MAX_OUTSTANDING against a silent slave 1
    for (int i = 0; i < 4; i++) begin
      cyc(); req(32'hF000_0000, 5'b00010);
      @(negedge clk); chk("t3_gnt_fill", m_gnt, 1);
    end
    cyc(); @(negedge clk); chk("t3_gnt_full", m_gnt, 0); chk("t3_sreq_full", s_req, 0);
    cyc(); @(negedge clk); chk("t3_gnt_full2", m_gnt, 0);
    cyc(); s_rvalid = 5'b00010; s_rdata[1*32 +: 32] = 32'hA0;
    @(negedge clk); chk("t3_rd0", m_rdata, 32'hA0); chk("t3_nobypass", m_gnt, 0);
    cyc(); s_rvalid = '0;
    @(negedge clk); chk("t3_gnt_after_pop", m_gnt, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(); idle(); s_rvalid = 5'b00010; s_rdata[1*32 +: 32] = 32'hA0 + i;
      @(negedge clk); chk("t3_rd_order", m_rdata, 32'hA0 + i);
    end
    cyc(); idle();
    @(negedge clk); chk("t3_empty_rv", m_rvalid, 0); chk("t3_proto", proto_err, 0);

    // 4: slave 3 answers before slave 1 at the head
    cyc(); req(32'hF000_0010, 5'b00010);
    cyc(); req(32'hF010_0000, 5'b01000);
    cyc(); idle(); s_rvalid = 5'b01000; s_rdata[3*32 +: 32] = 32'h33;
    @(negedge clk); chk("t4_rv_blocked", m_rvalid, 0);
    cyc(); s_rvalid = 5'b00010; s_rdata[1*32 +: 32] = 32'h11;
    @(negedge clk); chk("t4_rd1", m_rdata, 32'h11); chk("t4_proto", proto_err, 1);
    cyc(); s_rvalid = 5'b01000;
    @(negedge clk); chk("t4_rd3", m_rdata, 32'h33);

    // 5: rule rewrite, effective one cycle later
    cyc(); idle(); req(32'hF020_0000, '0);
    cfg_we = 1; cfg_idx = 3; cfg_start = 32'hF020_0000; cfg_end = 32'hF021_0000;
    cfg_slave = 4; cfg_valid = 1;
    @(negedge clk); chk("t5_old_gnt", m_gnt, 1); chk("t5_old_sreq", s_req, 0);
    cyc(); cfg_we = 0; s_gnt = 5'b10000;
    @(negedge clk); chk("t5_new_sreq", s_req, 5'b10000); chk("t5_err_rsp", m_err, 1);
    cyc(); idle(); s_rvalid = 5'b10000; s_rdata[4*32 +: 32] = 32'h44;
    @(negedge clk); chk("t5_rd4", m_rdata, 32'h44);
    cyc(); idle(); cfg_we = 1; cfg_idx = 0; cfg_start = 0; cfg_end = 0; cfg_slave = 7; cfg_valid = 0;
    cyc(); cfg_we = 0; req(32'h0000_0100, 5'b00001);
    @(negedge clk); chk("t5_ignored_wr", s_req, 5'b00001);
    cyc(); idle(); s_rvalid = 5'b00001;
    @(negedge clk); chk("t5_rv0", m_rvalid, 1);

    // 6: reset with two outstanding
    cyc(); idle(); req(32'hF001_0000, 5'b00100);
    cyc();
    cyc(); idle(); rst = 1;
    @(negedge clk); chk("t6_rst_rv", m_rvalid, 0);
    cyc(); rst = 0; s_rvalid = 5'b00100;
    @(negedge clk); chk("t6_post_rv", m_rvalid, 0); chk("t6_proto_clr", proto_err, 0);
    cyc(); s_rvalid = '0;
    @(negedge clk); chk("t6_proto_set", proto_err, 1);
    cyc(); req(32'hF010_0004, 5'b01000);
    @(negedge clk); chk("t6_table_restored", s_req, 5'b01000);
    cyc(); req(32'hF020_0000, '0); s_rvalid = 5'b01000;
    @(negedge clk); chk("t6_rewrite_gone", s_req, 0); chk("t6_err_gnt", m_gnt, 1);
    // end-exclusive boundary of rule 2
    cyc(); req(32'hF001_FFFF, 5'b00100); s_rvalid = '0;
    @(negedge clk); chk("bnd_last", s_req, 5'b00100);
    cyc(); req(32'hF002_0000, '0); s_rvalid = 5'b00100;
    @(negedge clk); chk("bnd_end", s_req, 0); chk("bnd_end_gnt", m_gnt, 1);
    cyc(); idle();
    @(negedge clk); chk("bnd_err_rsp", m_err, 1);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
